// File: rtl/dac_sample_scheduler.sv
// Round-robin sample scheduler feeding one SPI DAC driver. Each source owns a
// one-entry slot; the next sample is pre-loaded after every DAC handshake.

module dac_sample_slot #(
  parameter int DATA_W = 16
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr,
  input  logic              take,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  output logic [DATA_W-1:0] data
);
  always_ff @(posedge mclk) begin
    if (rst || flush) full <= 1'b0;
    else if (wr)      full <= 1'b1;
    else if (take)    full <= 1'b0;
  end

  always_ff @(posedge mclk) begin
    if (wr) data <= wdata;
  end
endmodule

module dac_sample_scheduler #(
  parameter int                NUM_SRC   = 4,
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] IDLE_CODE = DATA_W'(16'h8000),
  localparam int               IDX_W     = $clog2(NUM_SRC)
) (
  input  logic                      mclk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_SRC-1:0]        src_mask,
  input  logic [NUM_SRC-1:0]        s_valid,
  output logic [NUM_SRC-1:0]        s_ready,
  input  logic [NUM_SRC*DATA_W-1:0] s_data,
  output logic                      dac_valid,
  output logic [DATA_W-1:0]         dac_data,
  input  logic                      dac_ready,
  output logic [IDX_W-1:0]          dac_src,
  output logic                      underrun,
  output logic [15:0]               underrun_cnt
);
  localparam logic [IDX_W:0]   NSRC = (IDX_W+1)'(NUM_SRC);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {IDLE, ARB, HOLD} state_t;

  state_t                         state, state_nxt;
  logic [NUM_SRC-1:0]             slot_full, elig, wr, take;
  logic [NUM_SRC-1:0][DATA_W-1:0] slot_data, s_data_v;
  logic [IDX_W-1:0]               rr_ptr, gnt_idx, rr_nxt;
  logic [IDX_W:0]                 j;
  logic                           hit, primed, flush, und_evt;

  assign s_data_v = s_data;
  assign s_ready  = {NUM_SRC{en && (state != IDLE)}} & src_mask & ~slot_full;
  assign wr       = s_valid & s_ready;
  assign elig     = slot_full & src_mask;
  assign flush    = (state_nxt == IDLE);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_slot
    dac_sample_slot #(.DATA_W(DATA_W)) u_slot (
      .mclk  (mclk),
      .rst   (rst),
      .flush (flush),
      .wr    (wr[i]),
      .take  (take[i]),
      .wdata (s_data_v[i]),
      .full  (slot_full[i]),
      .data  (slot_data[i])
    );
  end

  // First eligible slot at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    hit     = 1'b0;
    gnt_idx = rr_ptr;
    j       = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (j >= NSRC) j = j - NSRC;
      if (!hit && elig[j[IDX_W-1:0]]) begin
        hit     = 1'b1;
        gnt_idx = j[IDX_W-1:0];
      end
    end
  end

  assign rr_nxt  = (gnt_idx == LAST) ? '0 : gnt_idx + IDX_W'(1);
  assign und_evt = (state == ARB) && !hit && primed;

  always_comb begin
    take = '0;
    if (state == ARB && hit) take[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = ARB;
      ARB:     state_nxt = en ? HOLD : IDLE;
      HOLD:    if (!en) state_nxt = IDLE;
               else if (dac_ready) state_nxt = ARB;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      state     <= IDLE;
      dac_valid <= 1'b0;
      dac_data  <= IDLE_CODE;
      dac_src   <= '0;
      rr_ptr    <= '0;
      primed    <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      dac_valid <= (state_nxt == HOLD);
      underrun  <= und_evt;
      // Entering or staying in IDLE overrides whatever ARB loaded this cycle.
      if (state_nxt == IDLE) begin
        dac_data <= IDLE_CODE;
        dac_src  <= '0;
        rr_ptr   <= '0;
        primed   <= 1'b0;
      end else if (state == ARB) begin
        primed <= 1'b1;
        if (hit) begin
          dac_data <= slot_data[gnt_idx];
          dac_src  <= gnt_idx;
          rr_ptr   <= rr_nxt;
        end
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) underrun_cnt <= '0;
    else if (und_evt && underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
  end
endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Bench for dac_sample_scheduler: directed scenarios plus random traffic,
// all checked every cycle against a transaction-level reference model.

module tb_dac_sample_scheduler;
  localparam int NS = 4;
  localparam int DW = 16;
  localparam int P_IDLE = 0, P_ARB = 1, P_HOLD = 2;

  logic              mclk = 1'b0;
  logic              rst, en, dac_ready;
  logic [NS-1:0]     src_mask, s_valid, s_ready;
  logic [NS*DW-1:0]  s_data;
  logic              dac_valid, underrun;
  logic [DW-1:0]     dac_data;
  logic [1:0]        dac_src;
  logic [15:0]       underrun_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 mclk = ~mclk;

  dac_sample_scheduler #(.NUM_SRC(NS), .DATA_W(DW), .IDLE_CODE(16'h8000)) dut (
    .mclk         (mclk),
    .rst          (rst),
    .en           (en),
    .src_mask     (src_mask),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .dac_valid    (dac_valid),
    .dac_data     (dac_data),
    .dac_ready    (dac_ready),
    .dac_src      (dac_src),
    .underrun     (underrun),
    .underrun_cnt (underrun_cnt)
  );

  // Reference model state
  int          m_phase, m_ptr, m_dsrc, m_cnt;
  bit          m_full[NS];
  logic [15:0] m_slot[NS];
  logic [15:0] m_dout;
  bit          m_primed, m_dvalid, m_und;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = P_IDLE; m_ptr = 0; m_dsrc = 0; m_cnt = 0;
    m_primed = 0; m_dvalid = 0; m_und = 0; m_dout = 16'h8000;
    for (int i = 0; i < NS; i++) m_full[i] = 0;
  endtask

  function automatic bit m_ready(input int i);
    return en && src_mask[i] && !m_full[i] && (m_phase != P_IDLE);
  endfunction

  task automatic model_edge();
    bit acc[NS];
    int g, np;
    if (rst) begin
      m_reset();
      return;
    end
    for (int i = 0; i < NS; i++) acc[i] = s_valid[i] && m_ready(i);
    g = -1; m_und = 0; np = m_phase;
    case (m_phase)
      P_IDLE: if (en) np = P_ARB;
      P_ARB: begin
        for (int k = 0; k < NS; k++) begin
          int c;
          c = (m_ptr + k) % NS;
          if (g < 0 && m_full[c] && src_mask[c]) g = c;
        end
        if (g >= 0) begin
          m_dout = m_slot[g]; m_dsrc = g; m_full[g] = 0; m_ptr = (g + 1) % NS;
        end else if (m_primed) begin
          m_und = 1;
          if (m_cnt < 65535) m_cnt++;
        end
        m_primed = 1;
        np = en ? P_HOLD : P_IDLE;
      end
      default: if (!en) np = P_IDLE; else if (dac_ready) np = P_ARB;
    endcase
    for (int i = 0; i < NS; i++)
      if (acc[i]) begin m_full[i] = 1; m_slot[i] = s_data[i*DW +: DW]; end
    if (np == P_IDLE) begin
      for (int i = 0; i < NS; i++) m_full[i] = 0;
      m_ptr = 0; m_primed = 0; m_dout = 16'h8000; m_dsrc = 0;
    end
    m_phase  = np;
    m_dvalid = (np == P_HOLD);
  endtask

  task automatic check_all();
    logic [NS-1:0] exp_rdy;
    for (int i = 0; i < NS; i++) exp_rdy[i] = m_ready(i);
    chk("dac_valid", 32'(dac_valid), 32'(m_dvalid));
    chk("dac_data", 32'(dac_data), 32'(m_dout));
    chk("dac_src", 32'(dac_src), 32'(m_dsrc));
    chk("underrun", 32'(underrun), 32'(m_und));
    chk("underrun_cnt", 32'(underrun_cnt), 32'(m_cnt));
    chk("s_ready", 32'(s_ready), 32'(exp_rdy));
  endtask

  task automatic tick();
    @(posedge mclk);
    model_edge();
    @(negedge mclk);
    check_all();
  endtask

  task automatic handshake(input int gap);
    repeat (gap) tick();
    dac_ready = 1'b1;
    tick();
    dac_ready = 1'b0;
    tick();
  endtask

  initial begin
    int gap;
    rst = 1'b1; en = 1'b0; dac_ready = 1'b0;
    src_mask = '1; s_valid = '0; s_data = '0;
    m_reset();
    @(negedge mclk);
    repeat (3) tick();
    chk("rst_valid", 32'(dac_valid), 32'd0);
    chk("rst_data", 32'(dac_data), 32'h8000);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_cnt", 32'(underrun_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Enable with no data: midscale presented two cycles after en
    en = 1'b1;
    tick();
    chk("arb_valid_low", 32'(dac_valid), 32'd0);
    tick();
    chk("en_lat_valid", 32'(dac_valid), 32'd1);
    chk("en_lat_data", 32'(dac_data), 32'h8000);
    chk("first_arb_no_und", 32'(underrun), 32'd0);
    repeat (3) handshake(4);
    chk("empty_cnt3", 32'(underrun_cnt), 32'd3);
    chk("empty_data", 32'(dac_data), 32'h8000);

    // Fairness
    for (int i = 0; i < NS; i++) s_data[i*DW +: DW] = 16'h1000 + 16'(i);
    s_valid = '1;
    for (int k = 0; k < 8; k++) begin
      handshake(96);
      chk("fair_src", 32'(dac_src), 32'(k % 4));
      chk("fair_data", 32'(dac_data), 32'h1000 + 32'(k % 4));
    end
    chk("fair_no_und", 32'(underrun_cnt), 32'd3);

    // Masking
    src_mask = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      handshake(6);
      chk("mask_src", 32'(dac_src), 32'((k % 2) * 2));
      chk("mask_rdy13", 32'({s_ready[3], s_ready[1]}), 32'd0);
    end
    src_mask = 4'b1111;
    handshake(6);
    chk("unmask_src", 32'(dac_src), 32'd3);
    handshake(6);
    handshake(6);
    chk("unmask_src1", 32'(dac_src), 32'd1);

    // Disable in HOLD with full slots
    en = 1'b0;
    tick();
    chk("dis_valid", 32'(dac_valid), 32'd0);
    chk("dis_data", 32'(dac_data), 32'h8000);
    chk("dis_ready", 32'(s_ready), 32'd0);
    s_valid = '0; en = 1'b1;
    tick();
    chk("flushed_ready", 32'(s_ready), 32'hF);
    tick();
    s_valid = '1;
    handshake(4);
    chk("ptr_restart", 32'(dac_src), 32'd0);

    // Sparse data from source 2 only
    en = 1'b0; s_valid = '0;
    tick();
    en = 1'b1;
    tick();
    tick();
    s_data[2*DW +: DW] = 16'hABCD; s_valid = 4'b0100;
    tick();
    s_valid = '0;
    handshake(3);
    chk("sparse_data", 32'(dac_data), 32'hABCD);
    chk("sparse_src", 32'(dac_src), 32'd2);
    for (int k = 0; k < 2; k++) begin
      handshake(3);
      chk("sparse_hold", 32'(dac_data), 32'hABCD);
      chk("sparse_und", 32'(underrun), 32'd1);
    end

    // Random traffic
    gap = 3;
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 19) == 0) src_mask = NS'($urandom);
      s_valid = NS'($urandom);
      for (int i = 0; i < NS; i++) s_data[i*DW +: DW] = DW'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      if (gap == 0) begin
        dac_ready = 1'b1;
        gap = int'($urandom_range(3, 9));
      end else begin
        dac_ready = 1'b0;
        gap--;
      end
      tick();
    end
    rst = 1'b0; dac_ready = 1'b0;

    // Counter saturation
    src_mask = '1; s_valid = '0; en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    tick();
    force dut.underrun_cnt = 16'hFFFE;
    m_cnt = 16'hFFFE;
    tick();
    release dut.underrun_cnt;
    chk("forced_cnt", 32'(underrun_cnt), 32'hFFFE);
    repeat (3) handshake(3);
    chk("sat_cnt", 32'(underrun_cnt), 32'hFFFF);

    // Synchronous reset in HOLD
    s_valid = '1;
    handshake(3);
    chk("pre_rst_valid", 32'(dac_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("hold_rst_valid", 32'(dac_valid), 32'd0);
    chk("hold_rst_data", 32'(dac_data), 32'h8000);
    chk("hold_rst_src", 32'(dac_src), 32'd0);
    chk("hold_rst_cnt", 32'(underrun_cnt), 32'd0);
    chk("hold_rst_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
